sync_hs_sender: RTL



---
 rtl/sync_hs_pkg.sv | 18 +
 rtl/sync_hs_sender_sync_chain.sv | 33 +++
 rtl/sync_hs_sender.sv | 116 +++++++++++
 3 files changed

// File: rtl/sync_hs_pkg.sv
// Shared types and helpers for the toggle request/acknowledge sender.
// The optional watchdog is enabled by defining SYNC_HS_TIMEOUT_EN.
package sync_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Counter width able to hold the value `cycles` itself.
  function automatic int timeout_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_hs_sender_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Every stage clears to 0 under the synchronous active-low reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!nrst) stage_reg[gi] <= 1'b0;
          else       stage_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!nrst) stage_reg[gi] <= 1'b0;
          else       stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/sync_hs_sender.sv
// Sending side of a toggle req/ack crossing: latches a word, flips req_out, waits for ack.
// Define SYNC_HS_TIMEOUT_EN to add a sticky watchdog error on a stalled acknowledge.
module sync_hs_sender
  import sync_hs_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             err
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("sync_hs_sender: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  state_t           state_reg;
  logic             req_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] data_reg;
  logic             ack_sync;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (CLK),
    .nrst (nRST),
    .d    (ack_in),
    .q    (ack_sync)
  );

`ifdef SYNC_HS_TIMEOUT_EN
  localparam int WD_W = timeout_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_reg;
  logic            err_reg;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      data_reg     <= '0;
      in_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
`ifdef SYNC_HS_TIMEOUT_EN
      wd_reg       <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg     <= in_data;
            state_reg    <= SETUP;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        // data_reg has been stable for a full cycle before the toggle goes out.
        SETUP: begin
          req_reg   <= ~req_reg;
          state_reg <= WAIT_ACK;
`ifdef SYNC_HS_TIMEOUT_EN
          wd_reg    <= '0;
`endif
        end
        WAIT_ACK: begin
          if (ack_sync == req_reg) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
          end
`ifdef SYNC_HS_TIMEOUT_EN
          // A timeout only flags; the FSM keeps waiting so the toggle phase stays aligned.
          if (wd_reg != WD_MAX) begin
            wd_reg <= wd_reg + 1'b1;
            if (wd_reg == WD_LAST) err_reg <= 1'b1;
          end
`endif
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_reg;
  assign busy     = busy_reg;
  assign data_out = data_reg;
  assign req_out  = req_reg;

`ifdef SYNC_HS_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule
